// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe -- pipelined multi-lane IEEE-754 binary floating-point multiplier.
//
// There are three register stages, so a result appears 3 cycles after its
// input transfer. All lanes share one valid/ready handshake and one global
// stall, so bubbles move through the pipe unchanged.
//   S1: unpack, classify operands, sign XOR, biased exponent sum
//   S2: (MANTISSA+1)x(MANTISSA+1) significand product
//   S3: normalise, round-to-nearest-even, exception resolve, output register
// Subnormal inputs are treated as zero. Results that would be subnormal are
// flushed to zero.
//
// Ports (W = EXPONENT+MANTISSA+1, lane i at bits [i*W +: W]):
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready depends only on the output side)
//   in_a, in_b           packed operand vectors
//   out_valid/out_ready  result handshake
//   out_c                packed products
//   out_flags            per lane {invalid, overflow, underflow, inexact}
module fp_mul_pipe #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23,
  parameter int LANES    = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [LANES*(EXPONENT+MANTISSA+1)-1:0] in_a,
  input  logic [LANES*(EXPONENT+MANTISSA+1)-1:0] in_b,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [LANES*(EXPONENT+MANTISSA+1)-1:0] out_c,
  output logic [LANES*4-1:0]                      out_flags
);
  localparam int E = EXPONENT;
  localparam int M = MANTISSA;
  localparam int W = E + M + 1;

  localparam logic signed [E+1:0] BIAS     = (E+2)'((1 << (E-1)) - 1);
  localparam logic signed [E+1:0] MAX_EXP  = (E+2)'((1 << E) - 1);
  localparam logic signed [E+1:0] ZERO_EXP = '0;
  localparam logic [E-1:0]        EXP_ONES = '1;

  typedef enum logic [1:0] {
    CLS_NORMAL,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } resultClass_t;

  logic s1Valid, s2Valid, outValid;
  logic stall, advance;

  // One global enable: every stage holds while the output beat waits.
  assign stall     = outValid & ~out_ready;
  assign advance   = ~stall;
  assign in_ready  = advance;
  assign out_valid = outValid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid  <= 1'b0;
      s2Valid  <= 1'b0;
      outValid <= 1'b0;
    end else if (advance) begin
      s1Valid  <= in_valid;
      s2Valid  <= s1Valid;
      outValid <= s2Valid;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : gLane
    // ---------------- S1: unpack and classify ----------------
    logic [W-1:0] opA, opB;
    logic [E-1:0] expA, expB;
    logic [M-1:0] fracA, fracB;
    logic         aZero, aInf, aNan, bZero, bInf, bNan;
    resultClass_t cls;

    assign opA   = in_a[gi*W +: W];
    assign opB   = in_b[gi*W +: W];
    assign expA  = opA[W-2:M];
    assign expB  = opB[W-2:M];
    assign fracA = opA[M-1:0];
    assign fracB = opB[M-1:0];
    assign aZero = (expA == '0);
    assign bZero = (expB == '0);
    assign aInf  = (expA == EXP_ONES) && (fracA == '0);
    assign bInf  = (expB == EXP_ONES) && (fracB == '0);
    assign aNan  = (expA == EXP_ONES) && (fracA != '0);
    assign bNan  = (expB == EXP_ONES) && (fracB != '0);

    always_comb begin
      cls = CLS_NORMAL;
      if (aNan || bNan || (aInf && bZero) || (bInf && aZero)) cls = CLS_NAN;
      else if (aInf || bInf)                                  cls = CLS_INF;
      else if (aZero || bZero)                                cls = CLS_ZERO;
    end

    logic                s1Sign;
    resultClass_t        s1Cls;
    logic signed [E+1:0] s1Exp;
    logic [M:0]          s1SigA, s1SigB;

    always_ff @(posedge clk) begin
      if (advance) begin
        s1Sign <= opA[W-1] ^ opB[W-1];
        s1Cls  <= cls;
        s1Exp  <= $signed({2'b00, expA}) + $signed({2'b00, expB}) - BIAS;
        s1SigA <= {1'b1, fracA};
        s1SigB <= {1'b1, fracB};
      end
    end

    // ---------------- S2: significand product ----------------
    logic                s2Sign;
    resultClass_t        s2Cls;
    logic signed [E+1:0] s2Exp;
    logic [2*M+1:0]      s2Prod;

    always_ff @(posedge clk) begin
      if (advance) begin
        s2Sign <= s1Sign;
        s2Cls  <= s1Cls;
        s2Exp  <= s1Exp;
        s2Prod <= {{(M+1){1'b0}}, s1SigA} * {{(M+1){1'b0}}, s1SigB};
      end
    end

    // ---------------- S3: normalise, round, resolve ----------------
    logic [2*M:0]        shifted;   // product with the leading one dropped
    logic [M-1:0]        fracKeep;
    logic                guardBit, stickyBit, roundUp;
    logic [M:0]          fracRound;
    logic signed [E+1:0] expFinal;
    logic [W-1:0]        cNext;
    logic [3:0]          flagsNext;

    always_comb begin
      // Product lies in [1,4); when it is >= 2 the window moves up one bit.
      shifted   = s2Prod[2*M+1] ? s2Prod[2*M:0] : {s2Prod[2*M-1:0], 1'b0};
      fracKeep  = shifted[2*M:M+1];
      guardBit  = shifted[M];
      stickyBit = |shifted[M-1:0];
      roundUp   = guardBit & (stickyBit | fracKeep[0]);
      // A carry out of the rounded fraction leaves its low bits all zero,
      // so only the exponent needs the extra increment.
      fracRound = {1'b0, fracKeep} + {{M{1'b0}}, roundUp};
      expFinal  = s2Exp + (E+2)'(s2Prod[2*M+1]) + (E+2)'(fracRound[M]);

      cNext     = {s2Sign, expFinal[E-1:0], fracRound[M-1:0]};
      flagsNext = {3'b000, guardBit | stickyBit};
      case (s2Cls)
        CLS_NAN: begin
          cNext     = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};
          flagsNext = 4'b1000;
        end
        CLS_INF: begin
          cNext     = {s2Sign, EXP_ONES, {M{1'b0}}};
          flagsNext = 4'b0000;
        end
        CLS_ZERO: begin
          cNext     = {s2Sign, {(W-1){1'b0}}};
          flagsNext = 4'b0000;
        end
        default: begin
          if (expFinal >= MAX_EXP) begin
            cNext     = {s2Sign, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
            flagsNext = 4'b0101;
          end else if (expFinal <= ZERO_EXP) begin
            cNext     = {s2Sign, {(W-1){1'b0}}};
            flagsNext = 4'b0011;
          end
        end
      endcase
    end

    logic [W-1:0] cReg;
    logic [3:0]   flagsReg;

    always_ff @(posedge clk) begin
      if (rst) begin
        cReg     <= '0;
        flagsReg <= '0;
      end else if (advance) begin
        cReg     <= cNext;
        flagsReg <= flagsNext;
      end
    end

    assign out_c[gi*W +: W]     = cReg;
    assign out_flags[gi*4 +: 4] = flagsReg;
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe -- directed self-checking bench for fp_mul_pipe.
// It drives a single-lane fp32 instance and a four-lane half-precision
// instance. Inputs change 1 time unit after the rising edge, and outputs are
// sampled before the next edge.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inValid, inReady, outValid, outReady;
  logic [31:0] inA, inB, outC;
  logic [3:0]  outFlags;

  logic        hInValid, hInReady, hOutValid, hOutReady;
  logic [63:0] hInA, hInB, hOutC;
  logic [15:0] hOutFlags;

  fp_mul_pipe #(.EXPONENT(8), .MANTISSA(23), .LANES(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in_a(inA), .in_b(inB),
    .out_valid(outValid), .out_ready(outReady), .out_c(outC), .out_flags(outFlags)
  );

  fp_mul_pipe #(.EXPONENT(5), .MANTISSA(10), .LANES(4)) dutHalf (
    .clk(clk), .rst(rst),
    .in_valid(hInValid), .in_ready(hInReady), .in_a(hInA), .in_b(hInB),
    .out_valid(hOutValid), .out_ready(hOutReady), .out_c(hOutC), .out_flags(hOutFlags)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkResult(input string tag, input logic [63:0] got, input logic [63:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Sends one vector, waits for the result and checks the latency, the
  // product and the flags. It is entered and left just after a clock edge,
  // with the pipe empty.
  task automatic runVector(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] wantC, input logic [3:0] wantF);
    int waitCycles;
    inValid  = 1'b1;
    inA      = a;
    inB      = b;
    outReady = 1'b1;
    #1;
    checkResult({tag, "_in_ready"}, 64'(inReady), 64'(1));
    @(posedge clk);
    #1;
    inValid    = 1'b0;
    waitCycles = 1;
    while (!outValid && waitCycles < 10) begin
      stepCycle();
      waitCycles++;
    end
    checkResult({tag, "_latency"}, 64'(waitCycles), 64'(3));
    checkResult({tag, "_c"}, 64'(outC), 64'(wantC));
    checkResult({tag, "_flags"}, 64'(outFlags), 64'(wantF));
    $display("[TB] %s: %h x %h -> %h flags=%b", tag, a, b, outC, outFlags);
  endtask

  localparam int NV = 19;
  string       vName [NV] = '{"mul_1p5x2", "rne_tie_even", "rne_below_half", "rne_tie_odd_up",
                              "round_up", "near_two", "ovf", "ovf_neg", "ovf_boundary",
                              "max_no_ovf", "unf", "unf_boundary", "inf_x_zero", "neg_inf",
                              "inf_x_neg", "neg_zero", "subnormal_flush", "nan_in", "neg_normal"};
  logic [31:0] vA [NV] = '{32'h3FC00000, 32'h3F800800, 32'h3F800001, 32'h3F800800,
                           32'h3FC00001, 32'h3FFFFFFF, 32'h7F000000, 32'hFF000000, 32'h7F000000,
                           32'h7F000000, 32'h00800000, 32'h00800000, 32'h7F800000, 32'hFF800000,
                           32'h7F800000, 32'h80000000, 32'h00000001, 32'h7FC12345, 32'hC0400000};
  logic [31:0] vB [NV] = '{32'h40000000, 32'h3F800800, 32'h3F800001, 32'h3F801800,
                           32'h3FC00001, 32'h3FFFFFFF, 32'h7F000000, 32'h7F000000, 32'h40000000,
                           32'h3FFFFFFF, 32'h3F000000, 32'h3F800000, 32'h00000000, 32'h40000000,
                           32'hC0000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000};
  logic [31:0] vC [NV] = '{32'h40400000, 32'h3F801000, 32'h3F800002, 32'h3F802002,
                           32'h40100002, 32'h407FFFFE, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F7FFFFF,
                           32'h7F7FFFFF, 32'h00000000, 32'h00800000, 32'h7FC00000, 32'hFF800000,
                           32'hFF800000, 32'h80000000, 32'h00000000, 32'h7FC00000, 32'hC0C00000};
  logic [3:0]  vF [NV] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001,
                           4'b0001, 4'b0001, 4'b0101, 4'b0101, 4'b0101,
                           4'b0000, 4'b0011, 4'b0000, 4'b1000, 4'b0000,
                           4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};

  // Backpressure stream: 2.0 x bpB[i] = bpC[i]
  logic [31:0] bpB [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000};
  logic [31:0] bpC [6] = '{32'h40800000, 32'h40C00000, 32'h41000000,
                           32'h41200000, 32'h41400000, 32'h41600000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  txIdx, rxIdx, holdLeft;
    bit  seenFirst;

    rst = 1'b1; inValid = 1'b0; inA = '0; inB = '0; outReady = 1'b1;
    hInValid = 1'b0; hInA = '0; hInB = '0; hOutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResult("reset_out_valid", 64'(outValid), 64'(0));
    checkResult("reset_out_c", 64'(outC), 64'(0));
    checkResult("reset_out_flags", 64'(outFlags), 64'(0));
    checkResult("reset_in_ready", 64'(inReady), 64'(1));
    checkResult("reset_half_out_valid", 64'(hOutValid), 64'(0));

    for (int i = 0; i < NV; i++) runVector(vName[i], vA[i], vB[i], vC[i], vF[i]);

    // ---- backpressure: out_ready low for 5 cycles from first out_valid ----
    stepCycle();
    txIdx = 0; rxIdx = 0; holdLeft = 0; seenFirst = 1'b0;
    for (int cyc = 0; cyc < 80 && rxIdx < 6; cyc++) begin
      if (cyc != 0) stepCycle();
      inValid = (txIdx < 6);
      inA     = 32'h40000000;
      inB     = bpB[(txIdx < 6) ? txIdx : 5];
      if (outValid && !seenFirst) begin
        seenFirst = 1'b1;
        holdLeft  = 5;
      end
      outReady = (holdLeft == 0);
      if (holdLeft > 0) holdLeft--;
      #1;
      if (outValid) begin
        if (rxIdx < 6) begin
          checkResult($sformatf("bp_c%0d", rxIdx), 64'(outC), 64'(bpC[rxIdx]));
          checkResult($sformatf("bp_flags%0d", rxIdx), 64'(outFlags), 64'(0));
        end else begin
          checkResult("bp_extra_beat", 64'(outValid), 64'(0));
        end
        if (!outReady) begin
          checkResult("bp_in_ready_low", 64'(inReady), 64'(0));
        end else begin
          $display("[TB] bp beat %0d -> %h", rxIdx, outC);
          rxIdx++;
        end
      end
      if (inValid && inReady) txIdx++;
    end
    checkResult("bp_rx_count", 64'(rxIdx), 64'(6));
    checkResult("bp_tx_count", 64'(txIdx), 64'(6));
    inValid = 1'b0;
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      checkResult("bp_no_dup", 64'(outValid), 64'(0));
      stepCycle();
    end

    // ---- reset with vectors in flight ----
    outReady = 1'b1;
    inValid  = 1'b1;
    inA      = 32'h40000000;
    inB      = 32'h40000000;
    stepCycle();
    inB = 32'h40400000;
    stepCycle();
    inB = 32'h40800000;
    rst = 1'b1;
    stepCycle();
    rst     = 1'b0;
    inValid = 1'b0;
    checkResult("rst_mid_out_valid", 64'(outValid), 64'(0));
    checkResult("rst_mid_out_c", 64'(outC), 64'(0));
    checkResult("rst_mid_out_flags", 64'(outFlags), 64'(0));
    checkResult("rst_mid_in_ready", 64'(inReady), 64'(1));
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      checkResult("rst_mid_no_leak", 64'(outValid), 64'(0));
    end
    $display("[TB] reset mid-stream: in-flight vectors discarded");

    // ---- half precision, four lanes in one beat ----
    begin
      int waitCycles;
      hInValid = 1'b1;
      hInA     = {16'h7C00, 16'h0400, 16'h7BFF, 16'h3C00};
      hInB     = {16'h0000, 16'h3800, 16'h4000, 16'h4000};
      stepCycle();
      hInValid   = 1'b0;
      waitCycles = 1;
      while (!hOutValid && waitCycles < 10) begin
        stepCycle();
        waitCycles++;
      end
      checkResult("half_latency", 64'(waitCycles), 64'(3));
      checkResult("half_c", hOutC, {16'h7E00, 16'h0000, 16'h7BFF, 16'h4000});
      checkResult("half_flags", 64'(hOutFlags), 64'(16'h8350));
      $display("[TB] half x4: %h flags=%h", hOutC, hOutFlags);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
